// File: rtl/cluster_pkg.sv
// Shared decode types and helpers for the cluster issue path.
package cluster_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       has_rd;
    logic       has_rs1;
    logic       has_rs2;
    logic       is_ctrl;
  } reg_dec_t;

  function automatic reg_dec_t reg_decode(input logic [31:0] instr);
    reg_dec_t d;
    d.rd      = instr[11:7];
    d.rs1     = instr[19:15];
    d.rs2     = instr[24:20];
    d.has_rd  = 1'b0;
    d.has_rs1 = 1'b0;
    d.has_rs2 = 1'b0;
    d.is_ctrl = 1'b0;
    case (instr[6:0])
      OP_R: begin
        d.has_rd  = 1'b1;
        d.has_rs1 = 1'b1;
        d.has_rs2 = 1'b1;
      end
      OP_LOAD, OP_IMM: begin
        d.has_rd  = 1'b1;
        d.has_rs1 = 1'b1;
      end
      OP_JALR: begin
        d.has_rd  = 1'b1;
        d.has_rs1 = 1'b1;
        d.is_ctrl = 1'b1;
      end
      OP_STORE: begin
        d.has_rs1 = 1'b1;
        d.has_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        d.has_rs1 = 1'b1;
        d.has_rs2 = 1'b1;
        d.is_ctrl = 1'b1;
      end
      OP_LUI, OP_AUIPC: d.has_rd = 1'b1;
      OP_JAL: begin
        d.has_rd  = 1'b1;
        d.is_ctrl = 1'b1;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/issue_fifo.sv
// Issue-queue storage: circular FIFO with occupancy count and synchronous flush.
module issue_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4,
  localparam int unsigned CntW = $clog2(Depth + 1),
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic [CntW-1:0]  count,
  output logic             empty,
  output logic             full
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: ;
      endcase
    end
  end

  // Payload needs no reset: entries are only read while count_q says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/cluster_issue_scheduler.sv
// In-order single-issue scheduler for the PE cluster with per-PE destination scoreboard.
// ISSUE_CPL_BYPASS_EN: when defined, completions feed the same-cycle issue decision.
module cluster_issue_scheduler
  import cluster_pkg::*;
#(
  parameter int unsigned NUM_PE = 4,
  parameter int unsigned QDEPTH = 4,
  localparam int unsigned CntW = $clog2(QDEPTH + 1),
  localparam int unsigned PeW  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [31:0]          in_pc,
  input  logic                 flush,
  input  logic [NUM_PE-1:0]    execution_complete,
  output logic [NUM_PE-1:0]    issue_valid,
  output logic [NUM_PE*32-1:0] instruction_outPE,
  output logic [NUM_PE*32-1:0] PCinPE,
  output logic [CntW-1:0]      q_count,
  output logic                 hazard_stall
);

  logic [63:0]       head;
  logic              head_empty, q_full;
  logic              ready_q;
  logic [NUM_PE-1:0] busy_q, busy_d, eff_busy;
  logic [NUM_PE-1:0] iv_q, iv_d;
  logic [4:0]        rd_q [NUM_PE];
  logic [31:0]       instr_q [NUM_PE];
  logic [31:0]       pc_q [NUM_PE];
  logic              ctrl_q, ctrl_d, eff_ctrl;
  logic [PeW-1:0]    ctrl_pe_q, ctrl_pe_d;
  logic              hazard, any_free, issue;
  logic [PeW-1:0]    sel;
  reg_dec_t          dec;

  // ready_q keeps in_ready low until the first edge after reset release.
  assign in_ready = ready_q && !q_full && !flush;

  issue_fifo #(
    .Width (64),
    .Depth (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (in_valid && in_ready),
    .wdata ({in_instr, in_pc}),
    .pop   (issue),
    .rdata (head),
    .count (q_count),
    .empty (head_empty),
    .full  (q_full)
  );

  assign dec = reg_decode(head[63:32]);

`ifdef ISSUE_CPL_BYPASS_EN
  assign eff_busy = busy_q & ~execution_complete;
  assign eff_ctrl = ctrl_q && !execution_complete[ctrl_pe_q];
`else
  assign eff_busy = busy_q;
  assign eff_ctrl = ctrl_q;
`endif

  // Lowest free PE wins; x0 destinations are stored as 0 so they never match.
  always_comb begin
    hazard   = 1'b0;
    any_free = 1'b0;
    sel      = '0;
    for (int p = NUM_PE - 1; p >= 0; p--) begin
      if (!eff_busy[p]) begin
        any_free = 1'b1;
        sel      = PeW'(p);
      end else if (rd_q[p] != 5'd0) begin
        if ((dec.has_rd  && dec.rd  == rd_q[p]) ||
            (dec.has_rs1 && dec.rs1 == rd_q[p]) ||
            (dec.has_rs2 && dec.rs2 == rd_q[p])) begin
          hazard = 1'b1;
        end
      end
    end
  end

  assign issue        = !flush && !head_empty && any_free && !eff_ctrl && !hazard;
  assign hazard_stall = !head_empty && !issue;

  always_comb begin
    busy_d    = busy_q & ~execution_complete;
    ctrl_d    = ctrl_q;
    ctrl_pe_d = ctrl_pe_q;
    iv_d      = '0;
    if (ctrl_q && execution_complete[ctrl_pe_q]) ctrl_d = 1'b0;
    if (issue) begin
      busy_d[sel] = 1'b1;
      iv_d[sel]   = 1'b1;
      if (dec.is_ctrl) begin
        ctrl_d    = 1'b1;
        ctrl_pe_d = sel;
      end
    end
    if (flush) ctrl_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q   <= 1'b0;
      busy_q    <= '0;
      iv_q      <= '0;
      ctrl_q    <= 1'b0;
      ctrl_pe_q <= '0;
      for (int p = 0; p < NUM_PE; p++) begin
        rd_q[p]    <= '0;
        instr_q[p] <= '0;
        pc_q[p]    <= '0;
      end
    end else begin
      ready_q   <= 1'b1;
      busy_q    <= busy_d;
      iv_q      <= iv_d;
      ctrl_q    <= ctrl_d;
      ctrl_pe_q <= ctrl_pe_d;
      if (issue) begin
        rd_q[sel]    <= dec.has_rd ? dec.rd : 5'd0;
        instr_q[sel] <= head[63:32];
        pc_q[sel]    <= head[31:0];
      end
    end
  end

  assign issue_valid = iv_q;

  always_comb begin
    instruction_outPE = '0;
    PCinPE            = '0;
    for (int p = 0; p < NUM_PE; p++) begin
      instruction_outPE[p*32 +: 32] = instr_q[p];
      PCinPE[p*32 +: 32]            = pc_q[p];
    end
  end

endmodule

// File: tb/tb_cluster_issue_scheduler.sv
// Randomised and directed bench for cluster_issue_scheduler against a queue-level reference model.
module tb_cluster_issue_scheduler;

  localparam int unsigned NUM_PE = 4;
  localparam int unsigned QDEPTH = 4;
`ifdef ISSUE_CPL_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         flush = 1'b0;
  logic [31:0]  in_instr = '0;
  logic [31:0]  in_pc = '0;
  logic [3:0]   execution_complete = '0;
  logic         in_ready, hazard_stall;
  logic [3:0]   issue_valid;
  logic [127:0] instruction_outPE, PCinPE;
  logic [2:0]   q_count;

  cluster_issue_scheduler #(
    .NUM_PE (NUM_PE),
    .QDEPTH (QDEPTH)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_instr           (in_instr),
    .in_pc              (in_pc),
    .flush              (flush),
    .execution_complete (execution_complete),
    .issue_valid        (issue_valid),
    .instruction_outPE  (instruction_outPE),
    .PCinPE             (PCinPE),
    .q_count            (q_count),
    .hazard_stall       (hazard_stall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pending queue, in-flight destination per PE, control barrier.
  logic [63:0] m_q[$];
  bit          m_busy[NUM_PE];
  logic [4:0]  m_rd[NUM_PE];
  logic [31:0] m_instr[NUM_PE];
  logic [31:0] m_pc[NUM_PE];
  logic [3:0]  m_iv;
  bit          m_ctrl;
  int          m_ctrl_pe;
  bit          m_ready;

  // {rd, rs1, rs2} actually used by the instruction; unused slots read as x0.
  function automatic logic [14:0] m_regs(input logic [31:0] ins);
    logic [4:0] rd  = ins[11:7];
    logic [4:0] rs1 = ins[19:15];
    logic [4:0] rs2 = ins[24:20];
    case (ins[6:0])
      7'h33:               return {rd, rs1, rs2};
      7'h03, 7'h13, 7'h67: return {rd, rs1, 5'd0};
      7'h23, 7'h63:        return {5'd0, rs1, rs2};
      7'h37, 7'h17, 7'h6f: return {rd, 10'd0};
      default:             return 15'd0;
    endcase
  endfunction

  function automatic bit m_is_ctrl(input logic [31:0] ins);
    return (ins[6:0] == 7'h63) || (ins[6:0] == 7'h6f) || (ins[6:0] == 7'h67);
  endfunction

  function automatic logic [3:0] m_busy_mask();
    logic [3:0] m = '0;
    for (int p = 0; p < NUM_PE; p++) m[p] = m_busy[p];
    return m;
  endfunction

  task automatic model_reset();
    m_q.delete();
    for (int p = 0; p < NUM_PE; p++) begin
      m_busy[p]  = 1'b0;
      m_rd[p]    = '0;
      m_instr[p] = '0;
      m_pc[p]    = '0;
    end
    m_iv      = '0;
    m_ctrl    = 1'b0;
    m_ctrl_pe = 0;
    m_ready   = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_issue_valid"}, issue_valid, m_iv);
    check_eq({tag, "_q_count"}, q_count, m_q.size());
    for (int p = 0; p < NUM_PE; p++) begin
      check_eq($sformatf("%s_instr_pe%0d", tag, p), instruction_outPE[p*32 +: 32], m_instr[p]);
      check_eq($sformatf("%s_pc_pe%0d", tag, p), PCinPE[p*32 +: 32], m_pc[p]);
    end
  endtask

  // One clock: drive at posedge+1, check combinational outputs, step model at the edge, recheck.
  task automatic cycle(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit fl, input logic [3:0] cpl);
    logic [14:0] h, r;
    logic [63:0] ent;
    bit          issue, haz, ctrl_eff, rdy;
    int          sel;
    in_valid = v;
    in_instr = ins;
    in_pc = pc;
    flush = fl;
    execution_complete = cpl;
    #1;
    ctrl_eff = m_ctrl && !(Bypass && cpl[m_ctrl_pe]);
    sel = -1;
    haz = 1'b0;
    h = '0;
    if (m_q.size() > 0) h = m_regs(m_q[0][63:32]);
    for (int p = NUM_PE - 1; p >= 0; p--) begin
      if (!m_busy[p] || (Bypass && cpl[p])) sel = p;
      else if (m_rd[p] != 5'd0 &&
               (h[14:10] == m_rd[p] || h[9:5] == m_rd[p] || h[4:0] == m_rd[p])) haz = 1'b1;
    end
    issue = !fl && (m_q.size() > 0) && (sel >= 0) && !ctrl_eff && !haz;
    rdy = m_ready && (m_q.size() < QDEPTH) && !fl;
    check_eq("in_ready", in_ready, rdy);
    check_eq("hazard_stall", hazard_stall, (m_q.size() > 0) && !issue);
    check_eq("q_count_pre", q_count, m_q.size());
    @(posedge clk);
    for (int p = 0; p < NUM_PE; p++) if (cpl[p]) m_busy[p] = 1'b0;
    if (m_ctrl && cpl[m_ctrl_pe]) m_ctrl = 1'b0;
    m_iv = '0;
    if (issue) begin
      ent = m_q.pop_front();
      r = m_regs(ent[63:32]);
      m_busy[sel]  = 1'b1;
      m_rd[sel]    = r[14:10];
      m_instr[sel] = ent[63:32];
      m_pc[sel]    = ent[31:0];
      m_iv[sel]    = 1'b1;
      if (m_is_ctrl(ent[63:32])) begin
        m_ctrl    = 1'b1;
        m_ctrl_pe = sel;
      end
    end
    if (fl) begin
      m_q.delete();
      m_ctrl = 1'b0;
    end else if (v && rdy) begin
      m_q.push_back({ins, pc});
    end
    m_ready = 1'b1;
    #1;
    check_outputs("post");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic drain();
    int n = 0;
    while ((m_q.size() > 0 || m_busy_mask() != '0) && n < 60) begin
      cycle(1'b0, '0, '0, 1'b0, m_busy_mask());
      n++;
    end
    check_eq("drain_bound", (n < 60), 1);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    flush = 1'b0;
    execution_complete = '0;
    in_instr = '0;
    in_pc = '0;
    #2 reset = 1'b0;
    #1 model_reset();
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_hazard_stall", hazard_stall, 0);
    check_outputs("rst");
    repeat (3) @(posedge clk);
    #1 check_eq("rst_hold_in_ready", in_ready, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1 m_ready = 1'b1;
    check_eq("rel_in_ready", in_ready, 1);
    check_eq("rel_q_count", q_count, 0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    logic [6:0]  op;
    case ($urandom_range(0, 9))
      0: op = 7'h33;
      1: op = 7'h03;
      2: op = 7'h13;
      3: op = 7'h67;
      4: op = 7'h23;
      5: op = 7'h63;
      6: op = 7'h37;
      7: op = 7'h17;
      8: op = 7'h6f;
      default: op = 7'h73;
    endcase
    w[6:0]   = op;
    w[11:7]  = 5'($urandom_range(0, 5));
    w[19:15] = 5'($urandom_range(0, 5));
    w[24:20] = 5'($urandom_range(0, 5));
    return w;
  endfunction

  initial begin
    logic [3:0] cpl;
    do_reset();

    // Independent adds issue back to back to PE0 then PE1.
    cycle(1'b1, 32'h003100B3, 32'h0000_0100, 1'b0, '0);
    cycle(1'b1, 32'h006283B3, 32'h0000_0104, 1'b0, '0);
    idle(3);
    drain();

    // RAW on x1 stalls until PE0 completes.
    cycle(1'b1, 32'h003100B3, 32'h0000_0200, 1'b0, '0);
    cycle(1'b1, 32'h00108293, 32'h0000_0204, 1'b0, '0);
    idle(3);
    cycle(1'b0, '0, '0, 1'b0, 4'b0001);
    idle(2);
    drain();

    // All PEs busy with x1..x4, then five dependants back up the queue.
    for (int i = 1; i <= 4; i++) cycle(1'b1, (i << 7) | 32'h13, 32'h300 + 4 * i, 1'b0, '0);
    idle(2);
    for (int i = 0; i < 5; i++)
      cycle(1'b1, (((i % 4) + 1) << 15) | ((10 + i) << 7) | 32'h0010_0013, 32'h400 + 4 * i,
            1'b0, '0);
    check_eq("full_q_count", q_count, 4);
    check_eq("full_in_ready", in_ready, 0);
    for (int p = 0; p < NUM_PE; p++) begin
      cycle(1'b0, '0, '0, 1'b0, 4'(1 << p));
      idle(2);
    end
    drain();

    // Branch blocks a following add; flush empties the queue; branch completion unblocks.
    cycle(1'b1, 32'h00208463, 32'h0000_0500, 1'b0, '0);
    cycle(1'b1, 32'h00A48433, 32'h0000_0504, 1'b0, '0);
    idle(3);
    cycle(1'b1, 32'h00A48433, 32'h0000_0508, 1'b1, '0);
    idle(1);
    cycle(1'b1, 32'h00A48433, 32'h0000_050C, 1'b0, '0);
    idle(2);
    cycle(1'b0, '0, '0, 1'b0, 4'b0001);
    idle(2);
    drain();

    // Writes to x0 never create a WAW stall.
    cycle(1'b1, 32'h00008013, 32'h0000_0600, 1'b0, '0);
    cycle(1'b1, 32'h00008013, 32'h0000_0604, 1'b0, '0);
    idle(3);
    drain();

    for (int c = 0; c < 1500; c++) begin
      if (c == 700) do_reset();
      cpl = '0;
      for (int p = 0; p < NUM_PE; p++)
        cpl[p] = m_busy[p] ? ($urandom_range(0, 99) < 25) : ($urandom_range(0, 99) < 4);
      cycle($urandom_range(0, 99) < 60, rand_instr(), $urandom, $urandom_range(0, 99) < 5, cpl);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
